// File: rtl/gpr_hilo_file.sv
// Architectural GPR file (32 x DATA_W, r0 hardwired zero) plus HI/LO pair, committed from writeback.
// Optional same-cycle write-through of both buses to the read outputs: define RF_WB_BYPASS_EN.
module gpr_hilo_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREG   = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ADDR_W+DATA_W:0]     wb_rf_bus,
   input  logic [2*DATA_W:0]          wb_hilo_bus,
   input  logic [ADDR_W-1:0]          raddr1,
   input  logic [ADDR_W-1:0]          raddr2,
   output logic [DATA_W-1:0]          rdata1,
   output logic [DATA_W-1:0]          rdata2,
   output logic [DATA_W-1:0]          hi_o,
   output logic [DATA_W-1:0]          lo_o
);

   // Writeback bus fields: {we, waddr, wdata} and {we, hi, lo}.
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              hilo_we;
   logic [DATA_W-1:0] hilo_hi;
   logic [DATA_W-1:0] hilo_lo;

   assign rf_we    = wb_rf_bus[ADDR_W+DATA_W];
   assign rf_waddr = wb_rf_bus[DATA_W +: ADDR_W];
   assign rf_wdata = wb_rf_bus[DATA_W-1:0];
   assign hilo_we  = wb_hilo_bus[2*DATA_W];
   assign hilo_hi  = wb_hilo_bus[DATA_W +: DATA_W];
   assign hilo_lo  = wb_hilo_bus[DATA_W-1:0];

   logic [DATA_W-1:0] gpr_q [NREG];
   logic [DATA_W-1:0] gpr_d [NREG];
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;

   // A write to r0 is dropped so the stored entry stays zero as well as the read.
   logic rf_commit;
   assign rf_commit = rf_we && (rf_waddr != '0);

   always_comb begin
      // NOTE: every next-state signal starts from its held value before any
      // conditional update, so no path leaves it unassigned and no latch is inferred.
      gpr_d = gpr_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            gpr_d[i] = '0;
         end
         hi_d = '0;
         lo_d = '0;
      end else begin
         if (rf_commit) begin
            gpr_d[rf_waddr] = rf_wdata;
         end
         if (hilo_we) begin
            hi_d = hilo_hi;
            lo_d = hilo_lo;
         end
      end
   end

   // NOTE: the register array is cleared on reset rather than left undefined,
   // because software may read any GPR before writing it and must see zero.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples its _d value
      // from before the edge, independent of statement order.
      gpr_q <= gpr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
   end

   // Stored-state reads; r0 is forced to zero at the port.
   logic [DATA_W-1:0] rd1_stored;
   logic [DATA_W-1:0] rd2_stored;

   assign rd1_stored = (raddr1 == '0) ? '0 : gpr_q[raddr1];
   assign rd2_stored = (raddr2 == '0) ? '0 : gpr_q[raddr2];

`ifdef RF_WB_BYPASS_EN
   // Write-through is masked during reset so the ports show the stored state.
   logic rf_byp_ok;
   logic hilo_byp_ok;

   assign rf_byp_ok   = !rst && rf_commit;
   assign hilo_byp_ok = !rst && hilo_we;

   assign rdata1 = (rf_byp_ok && (raddr1 == rf_waddr)) ? rf_wdata : rd1_stored;
   assign rdata2 = (rf_byp_ok && (raddr2 == rf_waddr)) ? rf_wdata : rd2_stored;
   assign hi_o   = hilo_byp_ok ? hilo_hi : hi_q;
   assign lo_o   = hilo_byp_ok ? hilo_lo : lo_q;
`else
   assign rdata1 = rd1_stored;
   assign rdata2 = rd2_stored;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
`endif

endmodule

// File: tb/tb_gpr_hilo_file.sv
// Directed bench for gpr_hilo_file; expectations follow RF_WB_BYPASS_EN when it is defined.
module tb_gpr_hilo_file;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

`ifdef RF_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                   clk;
   logic                   rst;
   logic [ADDR_W+DATA_W:0] wb_rf_bus;
   logic [2*DATA_W:0]      wb_hilo_bus;
   logic [ADDR_W-1:0]      raddr1;
   logic [ADDR_W-1:0]      raddr2;
   logic [DATA_W-1:0]      rdata1;
   logic [DATA_W-1:0]      rdata2;
   logic [DATA_W-1:0]      hi_o;
   logic [DATA_W-1:0]      lo_o;

   int total = 0;
   int bad   = 0;

   gpr_hilo_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_rf_bus   (wb_rf_bus),
      .wb_hilo_bus (wb_hilo_bus),
      .raddr1      (raddr1),
      .raddr2      (raddr2),
      .rdata1      (rdata1),
      .rdata2      (rdata2),
      .hi_o        (hi_o),
      .lo_o        (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                        input logic [DATA_W-1:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs then settle well away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rf(input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
      wb_rf_bus = {we, a, d};
   endtask

   task automatic set_hilo(input logic we, input logic [DATA_W-1:0] h,
                           input logic [DATA_W-1:0] l);
      wb_hilo_bus = {we, h, l};
   endtask

   initial begin
      rst = 1'b1;
      set_rf(1'b0, '0, '0);
      set_hilo(1'b0, '0, '0);
      raddr1 = 5'd1;
      raddr2 = 5'd31;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("reset_rdata1", rdata1, 32'h0);
      check("reset_rdata2", rdata2, 32'h0);
      check("reset_hi", hi_o, 32'h0);
      check("reset_lo", lo_o, 32'h0);

      // T1: reset beats a concurrent write
      set_rf(1'b1, 5'd5, 32'h0000_0011);
      set_hilo(1'b1, 32'h0000_0022, 32'h0000_0033);
      tick();
      set_rf(1'b0, '0, '0);
      set_hilo(1'b0, '0, '0);
      raddr1 = 5'd5;
      #1;
      check("t1_pre_r5", rdata1, 32'h0000_0011);
      check("t1_pre_hi", hi_o, 32'h0000_0022);
      rst = 1'b1;
      set_rf(1'b1, 5'd5, 32'hDEAD_BEEF);
      set_hilo(1'b1, 32'h0000_0001, 32'h0000_0009);
      #1;
      check("t1_rst_nobyp_r5", rdata1, 32'h0000_0011);
      check("t1_rst_nobyp_hi", hi_o, 32'h0000_0022);
      tick();
      rst = 1'b0;
      set_rf(1'b0, '0, '0);
      set_hilo(1'b0, '0, '0);
      #1;
      check("t1_r5", rdata1, 32'h0);
      check("t1_hi", hi_o, 32'h0);
      check("t1_lo", lo_o, 32'h0);

      // T2: r0 is hardwired zero
      set_rf(1'b1, 5'd0, 32'hFFFF_FFFF);
      raddr1 = 5'd0;
      #1;
      check("t2_r0_same", rdata1, 32'h0);
      tick();
      set_rf(1'b0, '0, '0);
      #1;
      check("t2_r0_next", rdata1, 32'h0);

      // T3: back-to-back writes, then bubbles with junk payload
      set_rf(1'b1, 5'd7, 32'h1234_5678);
      tick();
      set_rf(1'b1, 5'd8, 32'h0BAD_F00D);
      tick();
      set_rf(1'b0, 5'd7, 32'hCAFE_CAFE);
      raddr1 = 5'd7;
      raddr2 = 5'd8;
      #1;
      check("t3_r7", rdata1, 32'h1234_5678);
      check("t3_r8", rdata2, 32'h0BAD_F00D);
      tick();
      set_rf(1'b0, 5'd8, 32'h5555_5555);
      tick();
      check("t3_r7_hold", rdata1, 32'h1234_5678);
      check("t3_r8_hold", rdata2, 32'h0BAD_F00D);

      // T4: same-cycle read of the entry being written
      set_rf(1'b1, 5'd9, 32'h0000_0001);
      tick();
      set_rf(1'b1, 5'd9, 32'h0000_0002);
      raddr1 = 5'd9;
      raddr2 = 5'd9;
      #1;
      check("t4_same_p1", rdata1, BYP ? 32'h0000_0002 : 32'h0000_0001);
      check("t4_same_p2", rdata2, BYP ? 32'h0000_0002 : 32'h0000_0001);
      tick();
      set_rf(1'b0, '0, '0);
      #1;
      check("t4_next_p1", rdata1, 32'h0000_0002);
      check("t4_next_p2", rdata2, 32'h0000_0002);

      // T5: HI/LO update and hold
      set_hilo(1'b1, 32'hAAAA_0000, 32'h0000_BBBB);
      #1;
      check("t5_hi_same", hi_o, BYP ? 32'hAAAA_0000 : 32'h0);
      check("t5_lo_same", lo_o, BYP ? 32'h0000_BBBB : 32'h0);
      tick();
      set_hilo(1'b0, 32'h1234_0000, 32'h0000_5678);
      #1;
      check("t5_hi", hi_o, 32'hAAAA_0000);
      check("t5_lo", lo_o, 32'h0000_BBBB);
      tick();
      check("t5_hi_hold", hi_o, 32'hAAAA_0000);
      check("t5_lo_hold", lo_o, 32'h0000_BBBB);

      // T6: concurrent GPR and HI/LO writes, then reset mid-stream
      set_rf(1'b1, 5'd31, 32'h0000_0005);
      set_hilo(1'b1, 32'h0000_0006, 32'h0000_0007);
      tick();
      set_rf(1'b0, '0, '0);
      set_hilo(1'b0, '0, '0);
      raddr1 = 5'd31;
      raddr2 = 5'd7;
      #1;
      check("t6_r31", rdata1, 32'h0000_0005);
      check("t6_r7_kept", rdata2, 32'h1234_5678);
      check("t6_hi", hi_o, 32'h0000_0006);
      check("t6_lo", lo_o, 32'h0000_0007);
      rst = 1'b1;
      set_rf(1'b1, 5'd31, 32'h0000_0077);
      tick();
      rst = 1'b0;
      set_rf(1'b0, '0, '0);
      #1;
      check("t6_rst_r31", rdata1, 32'h0);
      check("t6_rst_r7", rdata2, 32'h0);
      check("t6_rst_hi", hi_o, 32'h0);
      check("t6_rst_lo", lo_o, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
